wb_intc: RTL and testbench

WB_INTC -- requirements
Module: wb_intc

---
 rtl/wb_intc_pkg.sv | 18 +
 rtl/wb_intc_src.sv | 40 ++++
 rtl/wb_intc.sv | 105 ++++++++++
 tb/tb_wb_intc.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_intc_pkg.sv
// Shared definitions for the wb_intc Wishbone interrupt controller:
// register map offsets (word address bits [3:2]) and the default source count.
package wb_intc_pkg;

    localparam int NUM_IRQ_DEFAULT = 8;

    typedef enum logic [1:0] {
        REG_PENDING = 2'd0,
        REG_ENABLE  = 2'd1,
        REG_ACTIVE  = 2'd2,
        REG_CLAIM   = 2'd3
    } reg_sel_e;

    function automatic reg_sel_e decode_reg(input logic [1:0] word_addr);
        return reg_sel_e'(word_addr);
    endfunction

endpackage

// File: rtl/wb_intc_src.sv
// Pending-bit capture for one interrupt source. Build option WB_INTC_EDGE_DETECT_EN
// selects rising-edge capture; otherwise the source is level-sensitive.
module wb_intc_src (
    input  logic clk_i,
    input  logic rst_i,
    input  logic src,
    input  logic clr,
    output logic pending
);

    logic set;

`ifdef WB_INTC_EDGE_DETECT_EN
    logic src_q;

    // src_q resets low, so a source already high after reset is seen as an edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            src_q <= 1'b0;
        end else begin
            src_q <= src;
        end
    end

    assign set = src & ~src_q;
`else
    assign set = src;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending <= 1'b0;
        end else begin
            pending <= (pending & ~clr) | set;
        end
    end

endmodule

// File: rtl/wb_intc.sv
// Wishbone interrupt controller: PENDING (W1C), ENABLE, ACTIVE and CLAIM registers
// with a registered irq_o. Build option WB_INTC_EDGE_DETECT_EN enables edge capture.
module wb_intc
    import wb_intc_pkg::*;
#(
    parameter int WB_DATA_WIDTH = 32,
    parameter int WB_ADDR_WIDTH = 32,
    parameter int WB_SEL_WIDTH  = 4,
    parameter int NUM_IRQ       = NUM_IRQ_DEFAULT
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [WB_ADDR_WIDTH-1:0] wb_addr_i,
    input  logic [WB_DATA_WIDTH-1:0] wb_data_i,
    input  logic                     wb_we_i,
    input  logic [WB_SEL_WIDTH-1:0]  wb_sel_i,
    input  logic                     wb_stb_i,
    input  logic                     wb_cyc_i,
    output logic                     wb_ack_o,
    output logic [WB_DATA_WIDTH-1:0] wb_data_o,
    input  logic [NUM_IRQ-1:0]       irq_i,
    output logic                     irq_o
);

    logic [NUM_IRQ-1:0]       pending;
    logic [NUM_IRQ-1:0]       enable;
    logic [NUM_IRQ-1:0]       active;
    logic [NUM_IRQ-1:0]       wr_mask;
    logic [NUM_IRQ-1:0]       pend_clr;
    logic [WB_DATA_WIDTH-1:0] claim;
    logic [WB_DATA_WIDTH-1:0] rd_data;
    logic                     req;
    logic                     wr_commit;
    reg_sel_e                 reg_sel;
    logic                     unused_bus;

    // A request is only accepted when no ack is outstanding, giving one ack per two cycles
    // for a held strobe. Writes commit in the ack cycle while the master still holds the bus.
    assign req       = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wr_commit = wb_ack_o & wb_cyc_i & wb_stb_i & wb_we_i;
    assign reg_sel   = decode_reg(wb_addr_i[3:2]);
    assign active    = pending & enable;

    assign unused_bus = ^{wb_addr_i, wb_data_i, wb_sel_i};

    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_lane
        assign wr_mask[i] = wb_sel_i[i/8];
    end

    assign pend_clr = (wr_commit && reg_sel == REG_PENDING)
                    ? (wb_data_i[NUM_IRQ-1:0] & wr_mask) : '0;

    for (genvar n = 0; n < NUM_IRQ; n++) begin : g_src
        wb_intc_src u_src (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .src     (irq_i[n]),
            .clr     (pend_clr[n]),
            .pending (pending[n])
        );
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            enable <= '0;
        end else if (wr_commit && reg_sel == REG_ENABLE) begin
            enable <= (enable & ~wr_mask) | (wb_data_i[NUM_IRQ-1:0] & wr_mask);
        end
    end

    // Scan from the top so the lowest-numbered active source wins.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        claim = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (active[i]) begin
                claim = WB_DATA_WIDTH'(i + 1);
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            REG_PENDING: rd_data[NUM_IRQ-1:0] = pending;
            REG_ENABLE:  rd_data[NUM_IRQ-1:0] = enable;
            REG_ACTIVE:  rd_data[NUM_IRQ-1:0] = active;
            REG_CLAIM:   rd_data = claim;
            default:     rd_data = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wb_ack_o  <= 1'b0;
            wb_data_o <= '0;
            irq_o     <= 1'b0;
        end else begin
            wb_ack_o  <= req;
            wb_data_o <= req ? rd_data : '0;
            irq_o     <= |active;
        end
    end

endmodule

// File: tb/tb_wb_intc.sv
// Self-checking bench for wb_intc: directed scenarios plus randomized bus and
// interrupt traffic compared against a cycle-level reference model.
module tb_wb_intc;
    import wb_intc_pkg::*;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = 4;
    localparam int NI = 8;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [AW-1:0] wb_addr_i;
    logic [DW-1:0] wb_data_i;
    logic          wb_we_i;
    logic [SW-1:0] wb_sel_i;
    logic          wb_stb_i;
    logic          wb_cyc_i;
    logic          wb_ack_o;
    logic [DW-1:0] wb_data_o;
    logic [NI-1:0] irq_i;
    logic          irq_o;

    wb_intc #(
        .WB_DATA_WIDTH (DW),
        .WB_ADDR_WIDTH (AW),
        .WB_SEL_WIDTH  (SW),
        .NUM_IRQ       (NI)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wb_addr_i (wb_addr_i),
        .wb_data_i (wb_data_i),
        .wb_we_i   (wb_we_i),
        .wb_sel_i  (wb_sel_i),
        .wb_stb_i  (wb_stb_i),
        .wb_cyc_i  (wb_cyc_i),
        .wb_ack_o  (wb_ack_o),
        .wb_data_o (wb_data_o),
        .irq_i     (irq_i),
        .irq_o     (irq_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference model state: register contents as seen after each clock edge.
    logic [NI-1:0] m_pend = '0;
    logic [NI-1:0] m_en   = '0;
    logic [NI-1:0] m_prev = '0;
    logic          m_irq  = 1'b0;
    logic [NI-1:0] m_clr  = '0;
    logic          m_en_wr  = 1'b0;
    logic [NI-1:0] m_en_val = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input reg_sel_e r);
        logic [31:0] v;
        v = '0;
        case (r)
            REG_PENDING: v[NI-1:0] = m_pend;
            REG_ENABLE:  v[NI-1:0] = m_en;
            REG_ACTIVE:  v[NI-1:0] = m_pend & m_en;
            default: begin
                for (int i = 0; i < NI; i++) begin
                    if (m_pend[i] && m_en[i] && v == 0) v = 32'(i + 1);
                end
            end
        endcase
        return v;
    endfunction

    // One clock: advance the model from pre-edge inputs, then compare irq_o.
    task automatic tick();
        logic [NI-1:0] set, n_pend, n_en, n_prev;
        logic          n_irq;
`ifdef WB_INTC_EDGE_DETECT_EN
        set = irq_i & ~m_prev;
`else
        set = irq_i;
`endif
        n_pend = (m_pend & ~m_clr) | set;
        n_en   = m_en_wr ? m_en_val : m_en;
        n_irq  = |(m_pend & m_en);
        n_prev = irq_i;
        @(posedge clk_i);
        #1;
        if (rst_i) begin
            m_pend = '0; m_en = '0; m_prev = '0; m_irq = 1'b0;
        end else begin
            m_pend = n_pend; m_en = n_en; m_prev = n_prev; m_irq = n_irq;
        end
        m_clr   = '0;
        m_en_wr = 1'b0;
        check("irq_o", {31'b0, irq_o}, {31'b0, m_irq});
    endtask

    task automatic bus_idle();
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        wb_sel_i = '0;   wb_data_i = '0;
    endtask

    task automatic drive(input reg_sel_e r, input logic we, input logic [31:0] d, input logic [3:0] s);
        logic [AW-1:0] a;
        a = $urandom();
        a[3:2] = r;
        wb_addr_i = a; wb_data_i = d; wb_we_i = we; wb_sel_i = s;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    endtask

    task automatic wb_read(input string tag, input reg_sel_e r, output logic [31:0] rd);
        logic [31:0] exp;
        exp = model_read(r);
        drive(r, 1'b0, $urandom(), 4'hF);
        tick();
        check({tag, "_ack"}, {31'b0, wb_ack_o}, 32'd1);
        check({tag, "_data"}, wb_data_o, exp);
        rd = wb_data_o;
        tick();
        bus_idle();
        check({tag, "_noack"}, {31'b0, wb_ack_o}, 32'd0);
        check({tag, "_zero"}, wb_data_o, 32'd0);
    endtask

    // Model side effects of a write that commits in the current (ack) cycle.
    task automatic model_write(input reg_sel_e r, input logic [31:0] d, input logic [3:0] s);
        logic [NI-1:0] mask;
        mask = s[0] ? '1 : '0;
        if (r == REG_PENDING) m_clr = d[NI-1:0] & mask;
        if (r == REG_ENABLE) begin
            m_en_wr  = 1'b1;
            m_en_val = (m_en & ~mask) | (d[NI-1:0] & mask);
        end
    endtask

    task automatic wb_write(input string tag, input reg_sel_e r, input logic [31:0] d, input logic [3:0] s);
        drive(r, 1'b1, d, s);
        tick();
        check({tag, "_ack"}, {31'b0, wb_ack_o}, 32'd1);
        model_write(r, d, s);
        tick();
        bus_idle();
        check({tag, "_noack"}, {31'b0, wb_ack_o}, 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] exp;
        reg_sel_e    r;

        rst_i = 1'b1;
        irq_i = '0;
        wb_addr_i = '0;
        bus_idle();
        tick();
        tick();
        check("rst_ack", {31'b0, wb_ack_o}, 32'd0);
        check("rst_data", wb_data_o, 32'd0);
        check("rst_irq", {31'b0, irq_o}, 32'd0);
        rst_i = 1'b0;
        tick();
        wb_read("rst_pend", REG_PENDING, rd);
        check("rst_pend_zero", rd, 32'd0);

        // Enabled source 0 rises: PENDING one edge later, irq_o one edge after that.
        wb_write("en1", REG_ENABLE, 32'h1, 4'hF);
        for (int i = 0; i < 4; i++) tick();
        irq_i[0] = 1'b1;
        tick();
        check("rise_irq_n1", {31'b0, irq_o}, 32'd0);
        tick();
        check("rise_irq_n2", {31'b0, irq_o}, 32'd1);
        irq_i[0] = 1'b0;
        wb_read("rise_pend", REG_PENDING, rd);
        check("rise_pend_val", rd, 32'h1);

        // PENDING = 0x5, clear bit 2 only.
        irq_i = 8'h04;
        tick();
        irq_i = '0;
        wb_read("p5", REG_PENDING, rd);
        check("p5_val", rd, 32'h5);
        wb_write("w1c4", REG_PENDING, 32'h4, 4'hF);
        wb_read("p1", REG_PENDING, rd);
        check("p1_val", rd, 32'h1);
        check("p1_irq", {31'b0, irq_o}, 32'd1);
        wb_write("en4", REG_ENABLE, 32'h4, 4'hF);
        tick();
        check("en4_irq", {31'b0, irq_o}, 32'd0);

        // CLAIM priority and update after W1C.
        wb_write("clr_all", REG_PENDING, 32'hFF, 4'hF);
        wb_write("en6", REG_ENABLE, 32'h6, 4'hF);
        irq_i = 8'h06;
        tick();
        irq_i = '0;
        wb_read("claim_a", REG_CLAIM, rd);
        check("claim_a_val", rd, 32'd2);
        wb_write("w1c2", REG_PENDING, 32'h2, 4'hF);
        wb_read("claim_b", REG_CLAIM, rd);
        check("claim_b_val", rd, 32'd3);
        wb_read("active", REG_ACTIVE, rd);

        // Writes with byte lane 0 disabled must not touch ENABLE.
        wb_write("en_nosel", REG_ENABLE, 32'hFF, 4'hE);
        wb_read("en_keep", REG_ENABLE, rd);
        check("en_keep_val", rd, 32'h6);
        wb_write("ro_active", REG_ACTIVE, 32'hFF, 4'hF);
        wb_write("ro_claim", REG_CLAIM, 32'hFF, 4'hF);

        // W1C of bit 0 in the same cycle as a new irq_i[0] event: set wins.
        irq_i = 8'h01;
        tick();
        irq_i = '0;
        tick();
        drive(REG_PENDING, 1'b1, 32'h1, 4'hF);
        tick();
        check("race_ack", {31'b0, wb_ack_o}, 32'd1);
        model_write(REG_PENDING, 32'h1, 4'hF);
        irq_i[0] = 1'b1;
        tick();
        bus_idle();
        irq_i = '0;
        wb_read("race", REG_PENDING, rd);
        check("race_bit0", {31'b0, rd[0]}, 32'd1);

        // Request held for six cycles: acks in cycles 2, 4 and 6 only.
        drive(REG_ENABLE, 1'b0, 32'h0, 4'hF);
        for (int c = 2; c <= 6; c++) begin
            exp = (c % 2 == 0) ? model_read(REG_ENABLE) : 32'd0;
            tick();
            check($sformatf("hold_ack_c%0d", c), {31'b0, wb_ack_o}, (c % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("hold_data_c%0d", c), wb_data_o, exp);
        end
        bus_idle();
        tick();
        check("hold_ack_c7", {31'b0, wb_ack_o}, 32'd0);

        // Randomized traffic against the model.
        for (int it = 0; it < 60; it++) begin
            irq_i = $urandom();
            case ($urandom_range(0, 3))
                0: begin
                    r = reg_sel_e'($urandom_range(0, 3));
                    wb_read($sformatf("rnd_rd%0d", it), r, rd);
                end
                1: wb_write($sformatf("rnd_en%0d", it), REG_ENABLE, $urandom(), 4'($urandom()));
                2: wb_write($sformatf("rnd_w1c%0d", it), REG_PENDING, $urandom(), 4'($urandom()));
                default: begin
                    for (int k = 0; k < $urandom_range(1, 3); k++) tick();
                end
            endcase
        end
        irq_i = '0;
        wb_read("rnd_final", REG_CLAIM, rd);

        // Reset in the middle of a read with every source pending.
        wb_write("en_ff", REG_ENABLE, 32'hFF, 4'hF);
        irq_i = 8'hFF;
        tick();
        irq_i = 8'h80;
        tick();
        wb_read("pend_ff", REG_PENDING, rd);
        check("pend_ff_val", rd, 32'hFF);
        drive(REG_PENDING, 1'b0, 32'h0, 4'hF);
        rst_i = 1'b1;
        tick();
        check("mid_rst_ack", {31'b0, wb_ack_o}, 32'd0);
        check("mid_rst_data", wb_data_o, 32'd0);
        check("mid_rst_irq", {31'b0, irq_o}, 32'd0);
        rst_i = 1'b0;
        bus_idle();
        tick();
        check("post_rst_ack", {31'b0, wb_ack_o}, 32'd0);
        wb_read("post_rst_pend", REG_PENDING, rd);
        check("post_rst_pend_val", rd, 32'h80);
        wb_read("post_rst_en", REG_ENABLE, rd);
        check("post_rst_en_val", rd, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
